multiport_register_file: RTL
============================

MULTIPORT_REGISTER_FILE -- requirements
Module: multiport_register_file

Interface
REQ-001 SHALL have parameter NUM_ENTRY, default 16: number of storage entries.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4: address width; NUM_ENTRY <= 2**ADDR_WIDTH.
REQ-003 SHALL have parameter DATA_WIDTH, default 16: entry width in bits.
REQ-004 SHALL have parameter NUM_RD_PORTS, default 2: number of independent read ports, >= 1.
REQ-005 SHALL have parameter RD_LATENCY, default 0: 0 = combinational read, 1 = registered read.
REQ-006 SHALL have parameter BYPASS, default 1: 1 = same-cycle write data is forwarded to matching reads.
REQ-007 SHALL have one clock and a synchronous, active-high reset.
REQ-008 clk  input  1  clock; all state updates on rising edge.
REQ-009 rst  input  1  synchronous active-high reset.
REQ-010 clr  input  1  flash-invalidate all entries.
REQ-011 wr_en  input  1  write strobe.
REQ-012 wr_addr  input  ADDR_WIDTH  write address.
REQ-013 wr_data  input  DATA_WIDTH  write data.
REQ-014 wr_mask  input  DATA_WIDTH  per-bit write enable; 1 = bit updated.
REQ-015 rd_addr  input  NUM_RD_PORTS*ADDR_WIDTH  read addresses; port p occupies bits [p*ADDR_WIDTH +: ADDR_WIDTH].
REQ-016 rd_data  output  NUM_RD_PORTS*DATA_WIDTH  read data, same packing as rd_addr.
REQ-017 rd_valid  output  NUM_RD_PORTS  1 = addressed entry holds valid data.

Function
REQ-018 SHALL keep one valid bit per entry; the data array itself SHALL NOT be reset.
REQ-019 Write (wr_en=1, clr=0, rst=0, wr_addr < NUM_ENTRY): at the edge, entry[a] <= (wr_data & wr_mask) | (old & ~wr_mask), valid[a] <= 1.
REQ-020 Write to an invalid entry SHALL treat old as all-zero, i.e. store wr_data & wr_mask.
REQ-021 wr_addr >= NUM_ENTRY: write SHALL be ignored, no state change.
REQ-022 clr=1: at the edge all valid bits <= 0; a simultaneous write SHALL be discarded (clr has priority).
REQ-023 Read of an invalid or out-of-range entry SHALL return rd_data = 0, rd_valid = 0.
REQ-024 RD_LATENCY=0: rd_data/rd_valid for each port SHALL be a combinational function of rd_addr and the current state.
REQ-025 RD_LATENCY=0, BYPASS=1: if wr_en=1, clr=0 and rd_addr == wr_addr (in range), the port SHALL return the merged post-write value per REQ-019/020 and rd_valid = 1 in the same cycle.
REQ-026 RD_LATENCY=0, BYPASS=0: reads SHALL return pre-write state in the write cycle.
REQ-027 RD_LATENCY=1: rd_addr is sampled at edge N; rd_data/rd_valid SHALL be presented after edge N and held until edge N+1.
REQ-028 RD_LATENCY=1, BYPASS=1: a write at the same edge to the same address SHALL be reflected in the registered output; BYPASS=0 SHALL register pre-write state.
REQ-029 RD_LATENCY=1: clr at the sampling edge SHALL yield rd_valid = 0, rd_data = 0 for that sample.
REQ-030 Any number of ports MAY read the same address concurrently; each SHALL receive identical results.
REQ-031 Ports SHALL be independent; no arbitration or stall exists.

Reset
REQ-032 rst=1 at an edge SHALL clear all valid bits; rst SHALL override clr and wr_en.
REQ-033 RD_LATENCY=1: rst SHALL clear registered rd_data to 0 and rd_valid to 0.
REQ-034 RD_LATENCY=0: after reset, every port SHALL read rd_data = 0, rd_valid = 0 until written.
REQ-035 rst asserted in the same cycle as a write SHALL discard the write.

Verification
REQ-036 Reset, then read addr 0..15 on all ports -> rd_data = 0, rd_valid = 0 for every read.
REQ-037 Write 0xBEEF to addr 3 with mask 0xFFFF, then mask 0x00FF data 0x1234 -> addr 3 reads 0xBE34, rd_valid = 1.
REQ-038 RD_LATENCY=0, BYPASS=1: write 0xA5A5 to addr 7 while port 0 reads 7 and port 1 reads 6 (invalid) -> port 0 returns 0xA5A5/1 in the same cycle, port 1 returns 0/0; with BYPASS=0 port 0 returns 0/0.
REQ-039 Fill all entries, assert clr together with a write of 0x1111 to addr 5 -> next cycle all entries read 0/0, including addr 5.
REQ-040 RD_LATENCY=1: sample addr 9 at edge N with a same-edge write of 0x00FF -> output 0x00FF, rd_valid = 1 after edge N (BYPASS=1); output 0/0 (BYPASS=0, entry previously invalid).
REQ-041 With NUM_ENTRY=12, write to addr 13 -> ignored; read of addr 13 returns 0/0; entries 0..11 unchanged.

Source files
------------

// File: rtl/multiport_register_file.sv
// rtl/multiport_register_file.sv - register file with masked writes, per-entry valid bits and N read ports
// Reads can be combinational or registered, with optional forwarding of a write made in the same cycle.
module multiport_register_file #(
    parameter int NUM_ENTRY    = 16,
    parameter int ADDR_WIDTH   = 4,
    parameter int DATA_WIDTH   = 16,
    parameter int NUM_RD_PORTS = 2,
    parameter int RD_LATENCY   = 0,
    parameter int BYPASS       = 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               clr,
    input  logic                               wr_en,
    input  logic [ADDR_WIDTH-1:0]              wr_addr,
    input  logic [DATA_WIDTH-1:0]              wr_data,
    input  logic [DATA_WIDTH-1:0]              wr_mask,
    input  logic [NUM_RD_PORTS*ADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_RD_PORTS*DATA_WIDTH-1:0] rd_data,
    output logic [NUM_RD_PORTS-1:0]            rd_valid
);

    localparam int unsigned ENTRIES = NUM_ENTRY;

    logic [DATA_WIDTH-1:0] mem [NUM_ENTRY];
    logic [NUM_ENTRY-1:0]  valid;

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return 32'(a) < ENTRIES;
    endfunction

    // Out-of-range addresses are folded onto entry 0; every use is qualified by in_range.
    function automatic logic [ADDR_WIDTH-1:0] safe_idx(input logic [ADDR_WIDTH-1:0] a);
        return in_range(a) ? a : '0;
    endfunction

    logic [ADDR_WIDTH-1:0] wr_idx;
    logic                  wr_hit;
    logic [DATA_WIDTH-1:0] wr_old;
    logic [DATA_WIDTH-1:0] wr_merged;

    assign wr_idx    = safe_idx(wr_addr);
    assign wr_hit    = wr_en & ~clr & ~rst & in_range(wr_addr);
    assign wr_old    = valid[wr_idx] ? mem[wr_idx] : '0;
    assign wr_merged = (wr_data & wr_mask) | (wr_old & ~wr_mask);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            valid <= '0;
        end else if (wr_hit) begin
            valid[wr_idx] <= 1'b1;
        end
    end

    // The data array has no reset; the valid bits alone decide what is visible.
    always_ff @(posedge clk) begin
        if (wr_hit) begin
            mem[wr_idx] <= wr_merged;
        end
    end

    for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_port
        logic [ADDR_WIDTH-1:0] addr;
        logic [ADDR_WIDTH-1:0] idx;
        logic                  stored_ok;
        logic [DATA_WIDTH-1:0] next_data;
        logic                  next_valid;

        assign addr      = rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
        assign idx       = safe_idx(addr);
        assign stored_ok = in_range(addr) & valid[idx];

        always_comb begin
            next_data  = '0;
            next_valid = 1'b0;
            if (BYPASS != 0 && wr_hit && addr == wr_addr) begin
                next_data  = wr_merged;
                next_valid = 1'b1;
            end else if (stored_ok) begin
                next_data  = mem[idx];
                next_valid = 1'b1;
            end
        end

        if (RD_LATENCY == 0) begin : g_comb
            assign rd_data[p*DATA_WIDTH +: DATA_WIDTH] = next_data;
            assign rd_valid[p]                         = next_valid;
        end else begin : g_reg
            logic [DATA_WIDTH-1:0] data_q;
            logic                  valid_q;

            always_ff @(posedge clk) begin
                if (rst || clr) begin
                    data_q  <= '0;
                    valid_q <= 1'b0;
                end else begin
                    data_q  <= next_data;
                    valid_q <= next_valid;
                end
            end

            assign rd_data[p*DATA_WIDTH +: DATA_WIDTH] = data_q;
            assign rd_valid[p]                         = valid_q;
        end
    end

endmodule
